k8088_bus_arbiter: RTL and testbench

- Shares the single-port system memory between the k8088 core and two bus masters: video scanout (high priority) and DMA (low priority).
- Steals memory cycles from the core by dropping its `chipen`; the core freezes in place while a master uses the bus.
- Sits between k8088, the video fetcher, the DMA engine and the synchronous-read block RAM (address sampled at edge N, data valid during cycle N+1).

---
 rtl/k8088_bus_pkg.sv | 17 +
 rtl/k8088_bus_arbiter_if.sv | 52 +++++
 rtl/k8088_dma_aging.sv | 39 +++
 rtl/k8088_bus_arbiter.sv | 121 ++++++++++++
 tb/tb_k8088_bus_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/k8088_bus_pkg.sv
// Shared types and constants for the k8088 memory arbiter.
package k8088_bus_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;

  // Owner of a stolen access, latched when the steal is taken.
  localparam logic SEL_VID = 1'b0;
  localparam logic SEL_DMA = 1'b1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RESTORE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/k8088_bus_arbiter_if.sv
// Bus bundle between the arbiter and its neighbours (core, video, DMA, RAM).
interface k8088_bus_arbiter_if;
  import k8088_bus_pkg::*;

  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_out;
  logic              cpu_we;
  logic              cpu_chipen;
  logic [DATA_W-1:0] cpu_in;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [DATA_W-1:0] vid_data;

  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_we;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  cpu_address, cpu_out, cpu_we,
    output cpu_chipen, cpu_in,
    input  vid_req, vid_addr,
    output vid_ack, vid_data,
    input  dma_req, dma_addr, dma_we, dma_wdata,
    output dma_ack, dma_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  // Environment side (core, masters and RAM together).
  modport master (
    output cpu_address, cpu_out, cpu_we,
    input  cpu_chipen, cpu_in,
    output vid_req, vid_addr,
    input  vid_ack, vid_data,
    output dma_req, dma_addr, dma_we, dma_wdata,
    input  dma_ack, dma_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/k8088_dma_aging.sv
// Counts cycles a pending DMA request goes unserved; raises force_o once the
// request has waited DMA_MAXWAIT cycles so it beats video for one grant.
module k8088_dma_aging #(
  parameter int unsigned DMA_MAXWAIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic dma_req_i,
  input  logic granted_i,
  output logic force_o
);

  localparam int WAIT_W = (DMA_MAXWAIT < 1) ? 1 : $clog2(DMA_MAXWAIT + 1);

  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;

  // Saturating wait count; cleared whenever DMA is served or stops asking.
  always_comb begin
    wait_d = wait_q;
    if (!dma_req_i || granted_i) begin
      wait_d = '0;
    end else if (wait_q < WAIT_W'(DMA_MAXWAIT)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // Wait counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign force_o = dma_req_i && (wait_q >= WAIT_W'(DMA_MAXWAIT));

endmodule

// File: rtl/k8088_bus_arbiter.sv
// Steals single cycles of the synchronous-read RAM from the k8088 core for
// video (high priority) and DMA (low priority, aged).
//
// state   | meaning
// --------+-------------------------------------------------------------
// RUN     | core owns the bus; a steal freezes the core this same cycle
// GRANT   | latched master address (and DMA write) on the RAM
// RESTORE | master data returns with ack; core address re-presented
module k8088_bus_arbiter
  import k8088_bus_pkg::*;
#(
  parameter int unsigned DMA_MAXWAIT = 16,
  parameter int unsigned CPU_MIN_RUN = 1
) (
  input  logic            clock,
  input  logic            reset,
  k8088_bus_arbiter_if.slave bus
);

  localparam int RUN_W = $clog2(CPU_MIN_RUN + 1);

  arb_state_t        state_q;
  logic [RUN_W-1:0]  run_cnt_q;
  logic              sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              vid_ack_q;
  logic              dma_ack_q;

  logic steal;
  logic dma_force;
  logic dma_wins;
  logic dma_owns;

  // Steal is blocked during reset so the core keeps its enable while reset is held.
  assign steal = (state_q == ST_RUN) && !reset && (bus.vid_req || bus.dma_req) &&
                 !bus.cpu_we && (run_cnt_q >= RUN_W'(CPU_MIN_RUN));

  assign dma_wins = dma_force || (bus.dma_req && !bus.vid_req);
  assign dma_owns = (state_q != ST_RUN) && (sel_q == SEL_DMA);

  k8088_dma_aging #(.DMA_MAXWAIT(DMA_MAXWAIT)) u_aging (
    .clock     (clock),
    .reset     (reset),
    .dma_req_i (bus.dma_req),
    .granted_i ((steal && dma_wins) || dma_owns),
    .force_o   (dma_force)
  );

  // Sequencer: RUN -> GRANT -> RESTORE -> RUN, acks registered into RESTORE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_RUN;
      run_cnt_q <= RUN_W'(CPU_MIN_RUN);
      sel_q     <= SEL_VID;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      vid_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
    end else begin
      vid_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (run_cnt_q < RUN_W'(CPU_MIN_RUN)) begin
            run_cnt_q <= run_cnt_q + RUN_W'(1);
          end
          if (steal) begin
            sel_q   <= dma_wins;
            addr_q  <= dma_wins ? bus.dma_addr : bus.vid_addr;
            we_q    <= dma_wins && bus.dma_we;
            wdata_q <= bus.dma_wdata;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          vid_ack_q <= (sel_q == SEL_VID);
          dma_ack_q <= (sel_q == SEL_DMA);
          state_q   <= ST_RESTORE;
        end
        ST_RESTORE: begin
          run_cnt_q <= '0;
          state_q   <= ST_RUN;
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  // RAM port mux: core address except during GRANT.
  always_comb begin
    bus.mem_addr  = bus.cpu_address;
    bus.mem_wdata = bus.cpu_out;
    bus.mem_we    = 1'b0;
    case (state_q)
      ST_RUN: begin
        bus.mem_we = bus.cpu_we;
      end
      ST_GRANT: begin
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_we    = (sel_q == SEL_DMA) && we_q;
      end
      default: begin
        bus.mem_we = 1'b0;
      end
    endcase
  end

  assign bus.cpu_chipen = (state_q == ST_RUN) && !steal;
  assign bus.cpu_in     = bus.mem_rdata;
  assign bus.vid_data   = bus.mem_rdata;
  assign bus.dma_rdata  = bus.mem_rdata;
  assign bus.vid_ack    = vid_ack_q;
  assign bus.dma_ack    = dma_ack_q;

endmodule

// File: tb/tb_k8088_bus_arbiter.sv
// Bench for k8088_bus_arbiter: cycle model of stolen accesses plus directed
// scenarios (idle, video read, DMA write, pending core write, DMA aging, reset).
module tb_k8088_bus_arbiter;
  localparam int MAXW   = 4;
  localparam int MINRUN = 1;

  logic clock = 1'b0;
  logic reset;
  always #20 clock = ~clock;

  k8088_bus_arbiter_if bus();

  k8088_bus_arbiter #(.DMA_MAXWAIT(MAXW), .CPU_MIN_RUN(MINRUN)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous-read, read-first RAM.
  logic [7:0] ram [0:1048575];
  logic [7:0] rdata;
  always @(posedge clock) begin
    rdata <= ram[bus.mem_addr];
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = rdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an access taken in cycle t has the master address on the RAM in
  // t+1 and its ack/data in t+2; the core is frozen t..t+2.
  int         age;       // 0 core cycle, 1 master address phase, 2 data phase
  int         since;     // core cycles since the last access finished
  int         mwait;     // cycles DMA has been waiting
  logic       win_dma;
  logic       lat_we;
  logic [19:0] lat_addr;
  logic [7:0] lat_wd;
  logic [7:0] m_rd;
  logic       rd_valid;
  logic       cmp_en;

  always @(negedge clock) begin
    if (cmp_en) begin
      logic        elig, win_now, e_chip, e_we;
      logic [19:0] e_addr;
      logic [7:0]  e_wd;
      elig    = (age == 0) && !reset && (bus.vid_req || bus.dma_req) &&
                !bus.cpu_we && (since >= MINRUN);
      win_now = bus.dma_req && ((mwait >= MAXW) || !bus.vid_req);
      e_chip  = (age == 0) && !elig;
      e_addr  = (age == 1) ? lat_addr : bus.cpu_address;
      e_we    = (age == 0) ? bus.cpu_we : ((age == 1) && win_dma && lat_we);
      e_wd    = (age == 1) ? lat_wd : bus.cpu_out;

      chk("m_chipen",   32'(bus.cpu_chipen), 32'(e_chip));
      chk("m_mem_addr", 32'(bus.mem_addr),   32'(e_addr));
      chk("m_mem_we",   32'(bus.mem_we),     32'(e_we));
      if (e_we) chk("m_mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
      chk("m_vid_ack",  32'(bus.vid_ack), 32'((age == 2) && !win_dma));
      chk("m_dma_ack",  32'(bus.dma_ack), 32'((age == 2) && win_dma));
      if (rd_valid) begin
        chk("m_cpu_in", 32'(bus.cpu_in), 32'(m_rd));
        if (age == 2 && !win_dma) chk("m_vid_data", 32'(bus.vid_data), 32'(m_rd));
        if (age == 2 && win_dma && !lat_we) chk("m_dma_rdata", 32'(bus.dma_rdata), 32'(m_rd));
      end

      m_rd     = ram[e_addr];
      rd_valid = 1'b1;

      if (reset) begin
        age = 0; since = MINRUN; mwait = 0;
      end else begin
        if (!bus.dma_req || (elig && win_now) || (age != 0 && win_dma)) mwait = 0;
        else if (mwait < MAXW) mwait++;
        case (age)
          0: begin
            if (since < 1000) since++;
            if (elig) begin
              win_dma  = win_now;
              lat_addr = win_now ? bus.dma_addr : bus.vid_addr;
              lat_we   = win_now && bus.dma_we;
              lat_wd   = bus.dma_wdata;
              age      = 1;
            end
          end
          1: age = 2;
          default: begin age = 0; since = 0; end
        endcase
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
  endtask

  initial begin
    #(40 * 5000);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    age = 0; since = MINRUN; mwait = 0; win_dma = 1'b0; lat_we = 1'b0;
    lat_addr = '0; lat_wd = '0; m_rd = '0; rd_valid = 1'b0; cmp_en = 1'b0;
    reset = 1'b1;
    bus.cpu_address = 20'hFFFF0; bus.cpu_out = 8'h00; bus.cpu_we = 1'b0;
    bus.vid_req = 1'b0; bus.vid_addr = 20'h0;
    bus.dma_req = 1'b0; bus.dma_addr = 20'h0; bus.dma_we = 1'b0; bus.dma_wdata = 8'h00;
    ram[20'hFFFF0] = 8'hEA;
    ram[20'hB8000] = 8'h41;
    ram[20'h00400] = 8'h00;
    ram[20'h00200] = 8'h00;

    cyc(); cmp_en = 1'b1;
    cyc(); at_neg();
    chk("rst_chipen",  32'(bus.cpu_chipen), 32'd1);
    chk("rst_vid_ack", 32'(bus.vid_ack), 32'd0);
    chk("rst_dma_ack", 32'(bus.dma_ack), 32'd0);
    chk("rst_mem_we",  32'(bus.mem_we), 32'd0);
    cyc(); reset = 1'b0;

    // Idle core fetch.
    for (int i = 0; i < 5; i++) begin
      at_neg();
      chk("idle_chipen",   32'(bus.cpu_chipen), 32'd1);
      chk("idle_mem_addr", 32'(bus.mem_addr), 32'hFFFF0);
      chk("idle_acks",     32'({bus.vid_ack, bus.dma_ack}), 32'd0);
      cyc();
    end

    // Video read of 0xB8000.
    bus.vid_addr = 20'hB8000; bus.vid_req = 1'b1;
    at_neg(); chk("vid_steal_chipen", 32'(bus.cpu_chipen), 32'd0);
    cyc(); at_neg();
    chk("vid_grant_addr", 32'(bus.mem_addr), 32'hB8000);
    chk("vid_grant_we",   32'(bus.mem_we), 32'd0);
    cyc(); bus.vid_req = 1'b0; at_neg();
    chk("vid_ack",         32'(bus.vid_ack), 32'd1);
    chk("vid_data",        32'(bus.vid_data), 32'h41);
    chk("vid_restore_addr", 32'(bus.mem_addr), 32'hFFFF0);
    chk("vid_restore_chipen", 32'(bus.cpu_chipen), 32'd0);
    cyc(); at_neg();
    chk("vid_resume_chipen", 32'(bus.cpu_chipen), 32'd1);
    chk("vid_resume_ack",    32'(bus.vid_ack), 32'd0);
    chk("vid_resume_opcode", 32'(bus.cpu_in), 32'hEA);
    cyc(); cyc();

    // DMA write 0x5A to 0x00400.
    bus.dma_addr = 20'h00400; bus.dma_we = 1'b1; bus.dma_wdata = 8'h5A; bus.dma_req = 1'b1;
    at_neg(); chk("dmaw_steal_chipen", 32'(bus.cpu_chipen), 32'd0);
    cyc(); at_neg();
    chk("dmaw_mem_we",    32'(bus.mem_we), 32'd1);
    chk("dmaw_mem_addr",  32'(bus.mem_addr), 32'h00400);
    chk("dmaw_mem_wdata", 32'(bus.mem_wdata), 32'h5A);
    cyc(); bus.dma_req = 1'b0; bus.dma_we = 1'b0; at_neg();
    chk("dmaw_ack", 32'(bus.dma_ack), 32'd1);
    cyc(); bus.cpu_address = 20'h00400; at_neg();
    chk("dmaw_core_chipen", 32'(bus.cpu_chipen), 32'd1);
    cyc(); bus.cpu_address = 20'hFFFF0; at_neg();
    chk("dmaw_core_read", 32'(bus.cpu_in), 32'h5A);

    // Core write pending when video asks.
    cyc();
    bus.cpu_address = 20'h00200; bus.cpu_out = 8'h77; bus.cpu_we = 1'b1;
    bus.vid_addr = 20'hB8000; bus.vid_req = 1'b1;
    at_neg();
    chk("cw_no_steal", 32'(bus.cpu_chipen), 32'd1);
    chk("cw_mem_we",   32'(bus.mem_we), 32'd1);
    chk("cw_mem_addr", 32'(bus.mem_addr), 32'h00200);
    cyc(); bus.cpu_we = 1'b0; bus.cpu_address = 20'hFFFF0; at_neg();
    chk("cw_steal_after", 32'(bus.cpu_chipen), 32'd0);
    cyc(); at_neg(); chk("cw_grant_addr", 32'(bus.mem_addr), 32'hB8000);
    cyc(); bus.vid_req = 1'b0; at_neg(); chk("cw_vid_ack", 32'(bus.vid_ack), 32'd1);
    cyc(); bus.cpu_address = 20'h00200; at_neg();
    cyc(); bus.cpu_address = 20'hFFFF0; at_neg();
    chk("cw_write_landed", 32'(bus.cpu_in), 32'h77);
    cyc(); cyc();

    // Starvation: video held, DMA read of 0x00400 pending.
    bus.vid_req = 1'b1; bus.vid_addr = 20'hB8000;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 20'h00400;
    at_neg(); chk("st_t0_chipen", 32'(bus.cpu_chipen), 32'd0);
    cyc(); at_neg(); chk("st_t1_vid_addr", 32'(bus.mem_addr), 32'hB8000);
    cyc(); at_neg();
    chk("st_t2_vid_ack", 32'(bus.vid_ack), 32'd1);
    chk("st_t2_dma_ack", 32'(bus.dma_ack), 32'd0);
    cyc(); at_neg(); chk("st_t3_min_run", 32'(bus.cpu_chipen), 32'd1);
    cyc(); at_neg();
    chk("st_t4_chipen", 32'(bus.cpu_chipen), 32'd0);
    chk("st_t4_wait",   32'(dut.u_aging.wait_q), 32'd4);
    cyc(); at_neg();
    chk("st_t5_dma_addr", 32'(bus.mem_addr), 32'h00400);
    chk("st_t5_mem_we",   32'(bus.mem_we), 32'd0);
    cyc(); bus.vid_req = 1'b0; bus.dma_req = 1'b0; at_neg();
    chk("st_t6_dma_ack",   32'(bus.dma_ack), 32'd1);
    chk("st_t6_dma_rdata", 32'(bus.dma_rdata), 32'h5A);
    chk("st_t6_vid_ack",   32'(bus.vid_ack), 32'd0);
    chk("st_t6_wait_clr",  32'(dut.u_aging.wait_q), 32'd0);
    cyc(); cyc();

    // Reset asserted during GRANT.
    bus.vid_req = 1'b1; bus.vid_addr = 20'hB8000;
    at_neg(); chk("rg_steal", 32'(bus.cpu_chipen), 32'd0);
    cyc(); reset = 1'b1; bus.vid_req = 1'b0; at_neg();
    chk("rg_grant_addr", 32'(bus.mem_addr), 32'hB8000);
    cyc(); reset = 1'b0; at_neg();
    chk("rg_chipen",  32'(bus.cpu_chipen), 32'd1);
    chk("rg_vid_ack", 32'(bus.vid_ack), 32'd0);
    chk("rg_dma_ack", 32'(bus.dma_ack), 32'd0);
    chk("rg_mem_we",  32'(bus.mem_we), 32'd0);
    cyc(); at_neg();
    chk("rg_no_late_ack", 32'(bus.vid_ack), 32'd0);
    chk("rg_run_chipen",  32'(bus.cpu_chipen), 32'd1);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
